// File: rtl/freq_sweep.sv
// freq_sweep: steps the commanded frequency from freq_start towards freq_stop, averages ADC power at
// each point and reports the strongest one. Define FREQ_SWEEP_RETRACK_EN to re-sweep periodically from DONE.
module freq_sweep #(
    parameter int FREQ_W      = 20,
    parameter int ADC_W       = 12,
    parameter int STARTUP_CYC = 200000,
    parameter int SETTLE_CYC  = 100000,
    parameter int AVG_LOG2    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swipt_alive,
    input  logic [1:0]        program_sel,   // "program" is a reserved word in SystemVerilog
    input  logic [ADC_W-1:0]  adc,
    input  logic              adc_valid,
    input  logic [FREQ_W-1:0] freq_start,
    input  logic [FREQ_W-1:0] freq_stop,
    input  logic [FREQ_W-1:0] freq_step,
    output logic [FREQ_W-1:0] new_freq,
    output logic [FREQ_W-1:0] best_freq,
    output logic [ADC_W-1:0]  best_adc,
    output logic              alg_done,
    output logic              busy
);
    localparam int CNT_MAX = (STARTUP_CYC > SETTLE_CYC) ? STARTUP_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ACC_W   = ADC_W + AVG_LOG2;
    localparam int SMP_W   = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] STARTUP_LOAD = CNT_W'(STARTUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SMP_W-1:0] SMP_LAST     = SMP_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {IDLE, STARTUP, SETTLE, ACQUIRE, COMPARE, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [SMP_W-1:0]  smp_q, smp_d;
    logic [FREQ_W-1:0] new_freq_q, new_freq_d;
    logic [FREQ_W-1:0] best_freq_q, best_freq_d;
    logic [ADC_W-1:0]  best_adc_q, best_adc_d;
    logic              alg_done_q, alg_done_d;

    logic              run_ok;
    logic              abort;
    logic [ADC_W-1:0]  avg;
    logic              better;
    logic [FREQ_W:0]   next_freq;
    logic              last_point;
    logic [FREQ_W-1:0] best_freq_upd;

    assign run_ok        = (program_sel == 2'b01);
    assign abort         = (state_q != IDLE) && !(swipt_alive && run_ok);
    assign avg           = acc_q[ACC_W-1:AVG_LOG2];
    assign better        = (avg > best_adc_q);
    assign best_freq_upd = better ? new_freq_q : best_freq_q;
    // One extra bit so a step past the top of the range cannot wrap back below freq_stop
    assign next_freq     = {1'b0, new_freq_q} + {1'b0, freq_step};
    assign last_point    = (freq_step == '0) || (next_freq > {1'b0, freq_stop});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            smp_q       <= '0;
            new_freq_q  <= '0;
            best_freq_q <= '0;
            best_adc_q  <= '0;
            alg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            smp_q       <= smp_d;
            new_freq_q  <= new_freq_d;
            best_freq_q <= best_freq_d;
            best_adc_q  <= best_adc_d;
            alg_done_q  <= alg_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (swipt_alive && run_ok) state_d = STARTUP;
                STARTUP: if (cnt_q == '0) state_d = SETTLE;
                SETTLE:  if (cnt_q == '0) state_d = ACQUIRE;
                ACQUIRE: if (adc_valid && (smp_q == SMP_LAST)) state_d = COMPARE;
                COMPARE: state_d = last_point ? DONE : SETTLE;
                DONE: begin
`ifdef FREQ_SWEEP_RETRACK_EN
                    if (cnt_q == '0) state_d = SETTLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        smp_d       = smp_q;
        new_freq_d  = new_freq_q;
        best_freq_d = best_freq_q;
        best_adc_d  = best_adc_q;
        alg_done_d  = alg_done_q;
        busy        = (state_q != IDLE) && (state_q != DONE);
        if (abort) begin
            // Link loss invalidates the result; a program change only pauses it
            if (!swipt_alive) alg_done_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    new_freq_d = freq_start;
                    if (swipt_alive && run_ok) begin
                        best_adc_d = '0;
                        alg_done_d = 1'b0;
                        cnt_d      = STARTUP_LOAD;
                    end
                end
                STARTUP: cnt_d = (cnt_q == '0) ? SETTLE_LOAD : cnt_q - CNT_W'(1);
                SETTLE: begin
                    if (cnt_q == '0) begin
                        acc_d = '0;
                        smp_d = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ACQUIRE: begin
                    if (adc_valid) begin
                        acc_d = acc_q + ACC_W'(adc);
                        smp_d = smp_q + SMP_W'(1);
                    end
                end
                COMPARE: begin
                    if (better) begin
                        best_adc_d  = avg;
                        best_freq_d = new_freq_q;
                    end
                    if (last_point) begin
                        new_freq_d = best_freq_upd;
                        alg_done_d = 1'b1;
`ifdef FREQ_SWEEP_RETRACK_EN
                        cnt_d      = STARTUP_LOAD;
`endif
                    end else begin
                        new_freq_d = next_freq[FREQ_W-1:0];
                        cnt_d      = SETTLE_LOAD;
                    end
                end
                DONE: begin
`ifdef FREQ_SWEEP_RETRACK_EN
                    if (cnt_q == '0) begin
                        new_freq_d = freq_start;
                        best_adc_d = '0;
                        cnt_d      = SETTLE_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign new_freq  = new_freq_q;
    assign best_freq = best_freq_q;
    assign best_adc  = best_adc_q;
    assign alg_done  = alg_done_q;

endmodule

// File: doc/freq_sweep.md
FREQ_SWEEP -- requirements
Module: freq_sweep

Interface
REQ-001 The block SHALL have parameter FREQ_W, default 20, frequency word width.
REQ-002 The block SHALL have parameter ADC_W, default 12, ADC sample width.
REQ-003 The block SHALL have parameter STARTUP_CYC, default 200000, start-up wait in cycles (2 ms).
REQ-004 The block SHALL have parameter SETTLE_CYC, default 100000, wait after each frequency change in cycles (1 ms).
REQ-005 The block SHALL have parameter AVG_LOG2, default 2, log2 of the number of ADC samples averaged per frequency point.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have port swipt_alive, input, 1 bit: link alive; low aborts the sweep.
REQ-009 The block SHALL have port program, input, 2 bits: sweep runs only while program == 2'b01.
REQ-010 The block SHALL have port adc, input, ADC_W bits: received-power sample.
REQ-011 The block SHALL have port adc_valid, input, 1 bit: adc is valid this cycle.
REQ-012 The block SHALL have ports freq_start, freq_stop and freq_step, input, FREQ_W bits each: sweep bounds and increment.
REQ-013 The block SHALL have port new_freq, output, FREQ_W bits: frequency currently commanded.
REQ-014 The block SHALL have port best_freq, output, FREQ_W bits: frequency with the highest averaged ADC.
REQ-015 The block SHALL have port best_adc, output, ADC_W bits: highest averaged ADC value.
REQ-016 The block SHALL have port alg_done, output, 1 bit: sweep complete.
REQ-017 The block SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.

Function
REQ-018 The FSM SHALL have states IDLE, STARTUP, SETTLE, ACQUIRE, COMPARE and DONE.
REQ-019 In IDLE, new_freq SHALL load freq_start every cycle.
REQ-020 IDLE SHALL move to STARTUP when swipt_alive=1 and program=01; on that transition best_adc and alg_done SHALL clear and the counter SHALL load STARTUP_CYC-1.
REQ-021 STARTUP SHALL count down to 0, then enter SETTLE with the counter loaded to SETTLE_CYC-1.
REQ-022 SETTLE SHALL count down to 0, then enter ACQUIRE with the accumulator and sample count cleared.
REQ-023 ACQUIRE SHALL add adc into an accumulator of width ADC_W+AVG_LOG2 on each adc_valid cycle, and SHALL enter COMPARE after 2^AVG_LOG2 samples; cycles without adc_valid SHALL stall without timeout.
REQ-024 In COMPARE, the average SHALL be the accumulator shifted right by AVG_LOG2 (truncating); if the average is strictly greater than best_adc, best_adc and best_freq SHALL take the average and new_freq; on ties the earlier frequency SHALL be kept.
REQ-025 In COMPARE, next = new_freq + freq_step SHALL be computed in FREQ_W+1 bits; if freq_step == 0 or next > freq_stop, the FSM SHALL enter DONE, otherwise new_freq SHALL become next and the FSM SHALL enter SETTLE.
REQ-026 If freq_start > freq_stop, only freq_start SHALL be measured before DONE.
REQ-027 On entering DONE, new_freq SHALL take best_freq (the updated value if COMPARE updated it this cycle) and alg_done SHALL go to 1.
REQ-028 In DONE, all outputs SHALL hold.
REQ-029 In any state other than IDLE, swipt_alive=0 SHALL force IDLE on the next edge with alg_done=0; best_freq SHALL hold.
REQ-030 In STARTUP through COMPARE, program != 01 SHALL force IDLE with alg_done held.
REQ-031 In DONE, program != 01 SHALL force IDLE with alg_done held.
REQ-032 When swipt_alive=0 and program != 01 occur together, the swipt_alive=0 rule SHALL take precedence.
REQ-033 Inputs freq_start, freq_stop and freq_step SHALL be sampled live; a change mid-sweep SHALL take effect at the next COMPARE.

Reset
REQ-034 While rst=1, the FSM SHALL be in IDLE and new_freq, best_freq, best_adc, counter and accumulator SHALL be 0, and alg_done and busy SHALL be 0, independent of clk.
REQ-035 Deasserting rst mid-sweep SHALL never resume the sweep; operation restarts from IDLE.

Configuration
REQ-036 When macro FREQ_SWEEP_RETRACK_EN is defined, DONE SHALL, after a further STARTUP_CYC cycles, reload new_freq to freq_start, clear best_adc, keep alg_done=1 and best_freq, and re-enter SETTLE for a fresh sweep.
REQ-037 When FREQ_SWEEP_RETRACK_EN is not defined, DONE SHALL be terminal until an abort or reset, with no re-sweep logic present.

Verification (STARTUP_CYC=10, SETTLE_CYC=4, AVG_LOG2=1)
REQ-038 Sweep start=100, stop=130, step=10, with averages 50/90/90/20 -> best_freq=110, best_adc=90, new_freq=110, alg_done=1.
REQ-039 Samples 7 and 8 at one point -> average 7 (truncating).
REQ-040 step=0, start=200, sample 33 -> one point measured, best_freq=200, alg_done=1.
REQ-041 start=0xFFFF0, stop=0xFFFFF, step=0x20 -> no wrap, DONE after one point.
REQ-042 swipt_alive low during ACQUIRE -> IDLE next edge, alg_done=0, new_freq=freq_start on the following cycle, best_freq held.
REQ-043 rst pulse mid-SETTLE -> all outputs 0 asynchronously; with FREQ_SWEEP_RETRACK_EN defined, DONE re-sweeps after 10 cycles with alg_done held at 1.
